// File: rtl/pipe_ctrl_pkg.sv
// Shared decode constants, control-bundle layout, trap helpers and FSM states
// for pipe_ctrl_unit (optional irq synchronizer: PIPE_CTRL_IRQ_SYNC_EN).
package pipe_ctrl_pkg;

  localparam int CTRL_W = 24;

  // Bit offsets of the control bundle (MSB first).
  localparam int CTRL_VALID_B    = 23;
  localparam int CTRL_REGWRITE_B = 22;
  localparam int CTRL_REGDST_B   = 20;
  localparam int CTRL_MEMREAD_B  = 19;
  localparam int CTRL_MEMWRITE_B = 18;
  localparam int CTRL_MEMTOREG_B = 16;
  localparam int CTRL_ALUSRC1_B  = 15;
  localparam int CTRL_ALUSRC2_B  = 14;
  localparam int CTRL_EXTOP_B    = 13;
  localparam int CTRL_LUOP_B     = 12;
  localparam int CTRL_SIGN_B     = 11;
  localparam int CTRL_ALUFUN_B   = 5;
  localparam int CTRL_BRANCH_B   = 4;
  localparam int CTRL_JUMP_B     = 3;
  localparam int CTRL_PCSRC_B    = 0;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic [1:0] regdst;
    logic       memread;
    logic       memwrite;
    logic [1:0] memtoreg;
    logic       alusrc1;
    logic       alusrc2;
    logic       extop;
    logic       luop;
    logic       sign;
    logic [5:0] alufun;
    logic       branch;
    logic       jump;
    logic [2:0] pcsrc;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NEQ = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101;
  localparam logic [5:0] ALU_LTZ = 6'b111011;
  localparam logic [5:0] ALU_GTZ = 6'b111111;

  localparam logic [2:0] PCSRC_SEQ  = 3'b000;
  localparam logic [2:0] PCSRC_JUMP = 3'b010;
  localparam logic [2:0] PCSRC_JR   = 3'b011;
  localparam logic [2:0] PCSRC_IRQ  = 3'b100;
  localparam logic [2:0] PCSRC_EXC  = 3'b101;

  // Register destination and writeback source selects.
  localparam logic [1:0] RD_RT   = 2'b00;
  localparam logic [1:0] RD_RD   = 2'b01;
  localparam logic [1:0] RD_RA   = 2'b10;
  localparam logic [1:0] RD_K0   = 2'b11;
  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_INJECT  = 2'd2,
    ST_SERVICE = 2'd3
  } state_e;

  // Trap slot: write PC+4 into $k0 and redirect through the given pcsrc.
  function automatic logic [CTRL_W-1:0] trap_bundle(input logic [2:0] pcsrc);
    ctrl_t c;
    c          = '0;
    c.valid    = 1'b1;
    c.regwrite = 1'b1;
    c.regdst   = RD_K0;
    c.memtoreg = MTR_PC4;
    c.pcsrc    = pcsrc;
    return c;
  endfunction

  // Index of the lowest set bit; 0 when none is set.
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      idx = v[i] ? 5'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational opcode/funct decoder producing the ID/EX control bundle and
// an undefined-instruction flag.
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic              instr_valid,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              undef_o
);

  ctrl_t c_s;
  logic  legal_s;

  // Decode table; an illegal or absent instruction yields an all-zero bundle.
  always_comb begin
    c_s     = '0;
    legal_s = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        c_s.regwrite = 1'b1;
        c_s.regdst   = RD_RD;
        case (funct)
          F_SLL:  begin c_s.alusrc1 = 1'b1; c_s.alufun = ALU_SLL; end
          F_SRL:  begin c_s.alusrc1 = 1'b1; c_s.alufun = ALU_SRL; end
          F_SRA:  begin c_s.alusrc1 = 1'b1; c_s.alufun = ALU_SRA; end
          F_JR: begin
            c_s.regwrite = 1'b0;
            c_s.regdst   = RD_RT;
            c_s.jump     = 1'b1;
            c_s.pcsrc    = PCSRC_JR;
          end
          F_JALR: begin
            c_s.memtoreg = MTR_PC4;
            c_s.jump     = 1'b1;
            c_s.pcsrc    = PCSRC_JR;
          end
          F_ADD:  begin c_s.sign = 1'b1; c_s.alufun = ALU_ADD; end
          F_ADDU: c_s.alufun = ALU_ADD;
          F_SUB:  begin c_s.sign = 1'b1; c_s.alufun = ALU_SUB; end
          F_SUBU: c_s.alufun = ALU_SUB;
          F_AND:  c_s.alufun = ALU_AND;
          F_OR:   c_s.alufun = ALU_OR;
          F_XOR:  c_s.alufun = ALU_XOR;
          F_NOR:  c_s.alufun = ALU_NOR;
          F_SLT:  begin c_s.sign = 1'b1; c_s.alufun = ALU_LT; end
          default: legal_s = 1'b0;
        endcase
      end
      OP_REGIMM: begin c_s.branch = 1'b1; c_s.extop = 1'b1; c_s.sign = 1'b1; c_s.alufun = ALU_LTZ; end
      OP_BEQ:    begin c_s.branch = 1'b1; c_s.extop = 1'b1; c_s.sign = 1'b1; c_s.alufun = ALU_EQ;  end
      OP_BNE:    begin c_s.branch = 1'b1; c_s.extop = 1'b1; c_s.sign = 1'b1; c_s.alufun = ALU_NEQ; end
      OP_BLEZ:   begin c_s.branch = 1'b1; c_s.extop = 1'b1; c_s.sign = 1'b1; c_s.alufun = ALU_LEZ; end
      OP_BGTZ:   begin c_s.branch = 1'b1; c_s.extop = 1'b1; c_s.sign = 1'b1; c_s.alufun = ALU_GTZ; end
      OP_J:      begin c_s.jump = 1'b1; c_s.pcsrc = PCSRC_JUMP; end
      OP_JAL: begin
        c_s.regwrite = 1'b1;
        c_s.regdst   = RD_RA;
        c_s.memtoreg = MTR_PC4;
        c_s.jump     = 1'b1;
        c_s.pcsrc    = PCSRC_JUMP;
      end
      OP_ADDI:  begin c_s.regwrite = 1'b1; c_s.alusrc2 = 1'b1; c_s.extop = 1'b1; c_s.sign = 1'b1; c_s.alufun = ALU_ADD; end
      OP_ADDIU: begin c_s.regwrite = 1'b1; c_s.alusrc2 = 1'b1; c_s.extop = 1'b1; c_s.alufun = ALU_ADD; end
      OP_SLTI:  begin c_s.regwrite = 1'b1; c_s.alusrc2 = 1'b1; c_s.extop = 1'b1; c_s.sign = 1'b1; c_s.alufun = ALU_LT; end
      OP_SLTIU: begin c_s.regwrite = 1'b1; c_s.alusrc2 = 1'b1; c_s.extop = 1'b1; c_s.alufun = ALU_LT; end
      OP_ANDI:  begin c_s.regwrite = 1'b1; c_s.alusrc2 = 1'b1; c_s.alufun = ALU_AND; end
      OP_LUI:   begin c_s.regwrite = 1'b1; c_s.alusrc2 = 1'b1; c_s.luop = 1'b1; c_s.alufun = ALU_ADD; end
      OP_LW: begin
        c_s.regwrite = 1'b1;
        c_s.memread  = 1'b1;
        c_s.memtoreg = MTR_MEM;
        c_s.alusrc2  = 1'b1;
        c_s.extop    = 1'b1;
        c_s.alufun   = ALU_ADD;
      end
      OP_SW: begin
        c_s.memwrite = 1'b1;
        c_s.alusrc2  = 1'b1;
        c_s.extop    = 1'b1;
        c_s.alufun   = ALU_ADD;
      end
      default: legal_s = 1'b0;
    endcase
    if (instr_valid && legal_s) begin
      c_s.valid = 1'b1;
    end else begin
      c_s = '0;
    end
    undef_o = instr_valid & ~legal_s;
  end

  assign ctrl_o = c_s;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID-stage control register, interrupt/undef trap injection FSM and kernel
// watchdog. Define PIPE_CTRL_IRQ_SYNC_EN for a 2-flop irq synchronizer.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter  int NUM_IRQ     = 4,
  parameter  int WDOG_CYCLES = 1024,
  localparam int IDW         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               pc_kernel,
  input  logic               stall_in,
  input  logic               flush_in,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  output logic [CTRL_W-1:0]  ctrl_o,
  output logic               irq_taken,
  output logic [IDW-1:0]     irq_id,
  output logic               exc_undef,
  output logic               kernel_hang
);

  localparam int WDW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic WD_EN = (WDOG_CYCLES > 0);
  localparam logic [WDW-1:0] WD_LAST = WDW'((WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0);

  state_e             state_q, state_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic               taken_q, taken_d;
  logic               undef_q, undef_d;
  logic [IDW-1:0]     irq_id_q, irq_id_d;
  logic [WDW-1:0]     wdog_q, wdog_d;
  logic               hang_q, hang_d;

  logic [CTRL_W-1:0]  dec_ctrl_s;
  logic               dec_undef_s;
  logic [NUM_IRQ-1:0] irq_sync_q;
  logic [NUM_IRQ-1:0] req_s;
  logic               shadow_s;
  logic               issue_s;
  logic               take_irq_s;

  ctrl_decode u_decode (
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .funct       (funct),
    .ctrl_o      (dec_ctrl_s),
    .undef_o     (dec_undef_s)
  );

`ifdef PIPE_CTRL_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] irq_meta_q;

  // Two-flop synchronizer for the asynchronous irq lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_meta_q <= '0;
      irq_sync_q <= '0;
    end else begin
      irq_meta_q <= irq;
      irq_sync_q <= irq_meta_q;
    end
  end
`else
  // Single sampling flop on the irq lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_sync_q <= '0;
    end else begin
      irq_sync_q <= irq;
    end
  end
`endif

  assign req_s    = irq_sync_q & irq_mask;
  // The slot after a branch/jump is its delay shadow; never trap there.
  assign shadow_s = ctrl_q[CTRL_BRANCH_B] | ctrl_q[CTRL_JUMP_B];
  assign issue_s  = instr_valid & ~stall_in & ~flush_in;
  assign take_irq_s = (state_q == ST_ARMED) & issue_s & ~pc_kernel & ~shadow_s & ~dec_undef_s;

  // Next-state logic for the ID/EX slot, trap FSM and watchdog.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    taken_d  = 1'b0;
    undef_d  = 1'b0;
    irq_id_d = irq_id_q;
    wdog_d   = wdog_q;
    hang_d   = hang_q;

    if (flush_in) begin
      ctrl_d = '0;
    end else if (stall_in) begin
      ctrl_d = ctrl_q;
    end else if (take_irq_s) begin
      ctrl_d  = trap_bundle(PCSRC_IRQ);
      taken_d = 1'b1;
    end else if (dec_undef_s) begin
      ctrl_d  = trap_bundle(PCSRC_EXC);
      undef_d = 1'b1;
    end else begin
      ctrl_d = dec_ctrl_s;
    end

    case (state_q)
      ST_IDLE: begin
        if (|req_s) begin
          irq_id_d = IDW'(lowest_set(32'(req_s)));
          state_d  = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (take_irq_s) begin
          state_d = ST_INJECT;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_INJECT: begin
        state_d = ST_SERVICE;
        wdog_d  = '0;
      end
      ST_SERVICE: begin
        if (instr_valid && !pc_kernel) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SERVICE;
        end
        if (WD_EN && !hang_q) begin
          if (wdog_q == WD_LAST) begin
            hang_d = 1'b1;
          end else begin
            wdog_d = wdog_q + WDW'(1);
          end
        end else begin
          wdog_d = wdog_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      taken_q  <= 1'b0;
      undef_q  <= 1'b0;
      irq_id_q <= '0;
      wdog_q   <= '0;
      hang_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      taken_q  <= taken_d;
      undef_q  <= undef_d;
      irq_id_q <= irq_id_d;
      wdog_q   <= wdog_d;
      hang_q   <= hang_d;
    end
  end

  assign ctrl_o      = ctrl_q;
  assign irq_taken   = taken_q;
  assign irq_id      = irq_id_q;
  assign exc_undef   = undef_q;
  assign kernel_hang = hang_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed, table-driven bench for pipe_ctrl_unit with WDOG_CYCLES=8.
module tb_pipe_ctrl_unit;

`ifdef PIPE_CTRL_IRQ_SYNC_EN
  localparam int ARM_LAT = 3;
`else
  localparam int ARM_LAT = 2;
`endif

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        pc_kernel;
  logic        stall_in;
  logic        flush_in;
  logic [3:0]  irq;
  logic [3:0]  irq_mask;
  logic [23:0] ctrl_o;
  logic        irq_taken;
  logic [1:0]  irq_id;
  logic        exc_undef;
  logic        kernel_hang;

  int errors = 0;
  int checks = 0;

  pipe_ctrl_unit #(.NUM_IRQ(4), .WDOG_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .funct       (funct),
    .pc_kernel   (pc_kernel),
    .stall_in    (stall_in),
    .flush_in    (flush_in),
    .irq         (irq),
    .irq_mask    (irq_mask),
    .ctrl_o      (ctrl_o),
    .irq_taken   (irq_taken),
    .irq_id      (irq_id),
    .exc_undef   (exc_undef),
    .kernel_hang (kernel_hang)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bundle with valid=1: {rw, regdst, mr, mw, memtoreg, a1, a2, ext, lu, sign, alufun, br, jp, pcsrc}
  function automatic logic [23:0] mk(input logic rw, input logic [1:0] rd, input logic mr,
                                     input logic mw, input logic [1:0] m2r, input logic a1,
                                     input logic a2, input logic ex, input logic lu, input logic sg,
                                     input logic [5:0] af, input logic br, input logic jp,
                                     input logic [2:0] pc);
    return {1'b1, rw, rd, mr, mw, m2r, a1, a2, ex, lu, sg, af, br, jp, pc};
  endfunction

  typedef struct {
    string       name;
    logic        vld;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [23:0] exp;
    logic        exp_undef;
  } vec_t;

  vec_t vecs[22];
  logic [23:0] addi_c, lw_c, trap_irq_c, trap_exc_c;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ins(input logic vld, input logic [5:0] op, input logic [5:0] fn, input logic kern);
    instr_valid = vld;
    opcode      = op;
    funct       = fn;
    pc_kernel   = kern;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Arm line(s) with no instructions flowing, then drop irq (request must persist).
  task automatic arm(input logic [3:0] lines, input logic [3:0] mask);
    irq      = lines;
    irq_mask = mask;
    ins(1'b0, 6'h00, 6'h00, 1'b0);
    for (int i = 0; i < ARM_LAT; i++) tick();
    irq = 4'b0000;
  endtask

  // Leave SERVICE: INJECT cycle, then one user-mode valid slot.
  task automatic finish_service(input string tag);
    ins(1'b1, 6'h08, 6'h00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk({tag, "_post_ctrl"}, 32'(ctrl_o), 32'(addi_c));
      chk({tag, "_post_taken"}, 32'(irq_taken), 32'd0);
    end
  endtask

  initial begin
    addi_c     = mk(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 3'b000);
    lw_c       = mk(1'b1, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'b000);
    trap_irq_c = mk(1'b1, 2'b11, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'b100);
    trap_exc_c = mk(1'b1, 2'b11, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'b101);

    vecs[0]  = '{"addi",  1'b1, 6'h08, 6'h00, addi_c, 1'b0};
    vecs[1]  = '{"add",   1'b1, 6'h00, 6'h20, mk(1, 2'b01, 0, 0, 2'b00, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 3'b000), 1'b0};
    vecs[2]  = '{"sll",   1'b1, 6'h00, 6'h00, mk(1, 2'b01, 0, 0, 2'b00, 1, 0, 0, 0, 0, 6'b100000, 0, 0, 3'b000), 1'b0};
    vecs[3]  = '{"sra",   1'b1, 6'h00, 6'h03, mk(1, 2'b01, 0, 0, 2'b00, 1, 0, 0, 0, 0, 6'b100011, 0, 0, 3'b000), 1'b0};
    vecs[4]  = '{"nor",   1'b1, 6'h00, 6'h27, mk(1, 2'b01, 0, 0, 2'b00, 0, 0, 0, 0, 0, 6'b010001, 0, 0, 3'b000), 1'b0};
    vecs[5]  = '{"slt",   1'b1, 6'h00, 6'h2a, mk(1, 2'b01, 0, 0, 2'b00, 0, 0, 0, 0, 1, 6'b110101, 0, 0, 3'b000), 1'b0};
    vecs[6]  = '{"jr",    1'b1, 6'h00, 6'h08, mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 6'b000000, 0, 1, 3'b011), 1'b0};
    vecs[7]  = '{"jalr",  1'b1, 6'h00, 6'h09, mk(1, 2'b01, 0, 0, 2'b10, 0, 0, 0, 0, 0, 6'b000000, 0, 1, 3'b011), 1'b0};
    vecs[8]  = '{"j",     1'b1, 6'h02, 6'h00, mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 6'b000000, 0, 1, 3'b010), 1'b0};
    vecs[9]  = '{"jal",   1'b1, 6'h03, 6'h00, mk(1, 2'b10, 0, 0, 2'b10, 0, 0, 0, 0, 0, 6'b000000, 0, 1, 3'b010), 1'b0};
    vecs[10] = '{"beq",   1'b1, 6'h04, 6'h00, mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 1, 6'b110011, 1, 0, 3'b000), 1'b0};
    vecs[11] = '{"bgtz",  1'b1, 6'h07, 6'h00, mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 1, 6'b111111, 1, 0, 3'b000), 1'b0};
    vecs[12] = '{"bltz",  1'b1, 6'h01, 6'h00, mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 1, 6'b111011, 1, 0, 3'b000), 1'b0};
    vecs[13] = '{"lw",    1'b1, 6'h23, 6'h00, lw_c, 1'b0};
    vecs[14] = '{"sw",    1'b1, 6'h2b, 6'h00, mk(0, 2'b00, 0, 1, 2'b00, 0, 1, 1, 0, 0, 6'b000000, 0, 0, 3'b000), 1'b0};
    vecs[15] = '{"lui",   1'b1, 6'h0f, 6'h00, mk(1, 2'b00, 0, 0, 2'b00, 0, 1, 0, 1, 0, 6'b000000, 0, 0, 3'b000), 1'b0};
    vecs[16] = '{"andi",  1'b1, 6'h0c, 6'h00, mk(1, 2'b00, 0, 0, 2'b00, 0, 1, 0, 0, 0, 6'b011000, 0, 0, 3'b000), 1'b0};
    vecs[17] = '{"sltiu", 1'b1, 6'h0b, 6'h00, mk(1, 2'b00, 0, 0, 2'b00, 0, 1, 1, 0, 0, 6'b110101, 0, 0, 3'b000), 1'b0};
    vecs[18] = '{"op3f",  1'b1, 6'h3f, 6'h00, trap_exc_c, 1'b1};
    vecs[19] = '{"fn01",  1'b1, 6'h00, 6'h01, trap_exc_c, 1'b1};
    vecs[20] = '{"ori",   1'b1, 6'h0d, 6'h00, trap_exc_c, 1'b1};
    vecs[21] = '{"novld", 1'b0, 6'h08, 6'h00, 24'h000000, 1'b0};

    reset = 1'b1;
    ins(1'b0, 6'h00, 6'h00, 1'b0);
    stall_in = 1'b0;
    flush_in = 1'b0;
    irq = 4'b0000;
    irq_mask = 4'b1111;
    do_reset();
    chk("rst_ctrl", 32'(ctrl_o), 32'd0);
    chk("rst_taken", 32'(irq_taken), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    chk("rst_undef", 32'(exc_undef), 32'd0);
    chk("rst_hang", 32'(kernel_hang), 32'd0);

    for (int i = 0; i < 22; i++) begin
      ins(vecs[i].vld, vecs[i].op, vecs[i].fn, 1'b0);
      tick();
      chk({"dec_", vecs[i].name}, 32'(ctrl_o), 32'(vecs[i].exp));
      chk({"undef_", vecs[i].name}, 32'(exc_undef), 32'(vecs[i].exp_undef));
    end

    // Interrupt latency with sequential code.
    ins(1'b1, 6'h08, 6'h00, 1'b0);
    irq = 4'b0001;
    irq_mask = 4'b1111;
    for (int i = 0; i < ARM_LAT; i++) begin
      tick();
      chk("lat_wait_taken", 32'(irq_taken), 32'd0);
      chk("lat_wait_ctrl", 32'(ctrl_o), 32'(addi_c));
    end
    tick();
    irq = 4'b0000;
    chk("lat_taken", 32'(irq_taken), 32'd1);
    chk("lat_id", 32'(irq_id), 32'd0);
    chk("lat_ctrl", 32'(ctrl_o), 32'(trap_irq_c));
    finish_service("lat");

    // Masked priority: line 1 masked off, line 2 wins; request persists after irq drops.
    arm(4'b0110, 4'b1101);
    ins(1'b1, 6'h08, 6'h00, 1'b0);
    tick();
    chk("prio_taken", 32'(irq_taken), 32'd1);
    chk("prio_id", 32'(irq_id), 32'd2);
    chk("prio_ctrl", 32'(ctrl_o), 32'(trap_irq_c));
    finish_service("prio");

    // Branch shadow defers injection by exactly one slot.
    irq = 4'b0001;
    irq_mask = 4'b1111;
    ins(1'b0, 6'h00, 6'h00, 1'b0);
    for (int i = 0; i < ARM_LAT - 1; i++) tick();
    ins(1'b1, 6'h04, 6'h00, 1'b0);
    tick();
    irq = 4'b0000;
    chk("shd_beq_taken", 32'(irq_taken), 32'd0);
    ins(1'b1, 6'h08, 6'h00, 1'b0);
    tick();
    chk("shd_block_taken", 32'(irq_taken), 32'd0);
    chk("shd_block_ctrl", 32'(ctrl_o), 32'(addi_c));
    tick();
    chk("shd_inj_taken", 32'(irq_taken), 32'd1);
    chk("shd_inj_ctrl", 32'(ctrl_o), 32'(trap_irq_c));
    finish_service("shd");

    // Undefined instruction beats an armed interrupt, which then follows.
    arm(4'b0001, 4'b1111);
    ins(1'b1, 6'h3f, 6'h00, 1'b0);
    tick();
    chk("ud_undef", 32'(exc_undef), 32'd1);
    chk("ud_taken", 32'(irq_taken), 32'd0);
    chk("ud_ctrl", 32'(ctrl_o), 32'(trap_exc_c));
    ins(1'b1, 6'h08, 6'h00, 1'b0);
    tick();
    chk("ud_next_undef", 32'(exc_undef), 32'd0);
    chk("ud_next_taken", 32'(irq_taken), 32'd1);
    chk("ud_next_ctrl", 32'(ctrl_o), 32'(trap_irq_c));
    finish_service("ud");

    // Stall holds the slot for 3 cycles, flush then bubbles it.
    ins(1'b1, 6'h08, 6'h00, 1'b0);
    tick();
    chk("stl_issue", 32'(ctrl_o), 32'(addi_c));
    ins(1'b1, 6'h23, 6'h00, 1'b0);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_hold", 32'(ctrl_o), 32'(addi_c));
    end
    flush_in = 1'b1;
    tick();
    chk("stl_flush", 32'(ctrl_o), 32'd0);
    stall_in = 1'b0;
    flush_in = 1'b0;

    // Reset mid-operation drops an armed request.
    arm(4'b0100, 4'b1111);
    chk("mid_id_armed", 32'(irq_id), 32'd2);
    do_reset();
    chk("mid_id_rst", 32'(irq_id), 32'd0);
    ins(1'b1, 6'h08, 6'h00, 1'b0);
    for (int i = 0; i < ARM_LAT + 2; i++) begin
      tick();
      chk("mid_taken", 32'(irq_taken), 32'd0);
    end

    // Kernel mode blocks injection; then watchdog in SERVICE.
    arm(4'b0001, 4'b1111);
    ins(1'b1, 6'h08, 6'h00, 1'b1);
    tick();
    chk("kern_block", 32'(irq_taken), 32'd0);
    ins(1'b1, 6'h08, 6'h00, 1'b0);
    tick();
    chk("kern_inj", 32'(irq_taken), 32'd1);
    ins(1'b1, 6'h08, 6'h00, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      if (i == 3) ins(1'b1, 6'h3f, 6'h00, 1'b1);
      else ins(1'b1, 6'h08, 6'h00, 1'b1);
      tick();
      if (i == 3) chk("wd_kern_undef", 32'(exc_undef), 32'd1);
      chk("wd_hang", 32'(kernel_hang), (i == 9) ? 32'd1 : 32'd0);
    end
    ins(1'b1, 6'h08, 6'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wd_sticky", 32'(kernel_hang), 32'd1);
    end
    do_reset();
    chk("wd_rst", 32'(kernel_hang), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
